// File: rtl/arb_pkg.sv
// Purpose: shared types and default widths for the arbiter requester controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arb_pkg;

  // Per-client controller states. Only REQ and XFER drive req.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam int ARB_N     = 4;
  localparam int ARB_CNT_W = 3;
  localparam int ARB_BURST = 4;
  localparam int ARB_TO_W  = 8;

  // Width of a beat counter that has to reach burst-1; never narrower than 1 bit.
  function automatic int beat_w(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/arb_req_client.sv
// Purpose: one requester client; FSM plus pending, beat and starvation counters.
// Latency: push -> pend_cnt +1 cycle -> req +1 cycle; done 1 cycle after last granted beat.
// Backpressure: none on push; a push at a saturated count is dropped and flags ovf.
//
// Ports: push (1-cycle transaction request), gnt (this client's grant bit),
// req (registered request), done (burst-complete pulse), pend_cnt (queued
// transactions), ovf/starve (sticky flags), idle_gnt (grant seen while idle,
// with the post-GAP cycle masked out).
module arb_req_client
  import arb_pkg::*;
#(
  parameter int CNT_W = ARB_CNT_W,
  parameter int BURST = ARB_BURST,
  parameter int TO_W  = ARB_TO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             gnt,
  output logic             req,
  output logic             done,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             ovf,
  output logic             starve,
  output logic             idle_gnt
);

  localparam int              BW        = beat_w(BURST);
  localparam logic [BW-1:0]   BEAT_LAST = BW'(BURST - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TO_W-1:0] TO_MAX    = '1;

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [BW-1:0]   beat;
  logic [TO_W-1:0] to_cnt;
  logic            post_gap;
  logic            active;
  logic            beat_vld;
  logic            last_beat;

  assign active    = (state == REQ) || (state == XFER);
  assign beat_vld  = active && gnt;
  assign last_beat = beat_vld && (beat == BEAT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. GAP looks at pend_cnt after the completing decrement.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pend_cnt != '0) state_nxt = REQ;
      REQ: begin
        if (last_beat) state_nxt = GAP;
        else if (gnt)  state_nxt = XFER;
      end
      XFER: begin
        if (last_beat) state_nxt = GAP;
        else if (!gnt) state_nxt = REQ;   // preempted; beat count is kept
      end
      GAP:     state_nxt = (pend_cnt != '0) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only, so gnt never reaches req combinationally.
  always_comb begin
    req      = active;
    idle_gnt = gnt && (state == IDLE) && !post_gap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      post_gap <= 1'b0;
      beat     <= '0;
    end else begin
      done     <= last_beat;
      post_gap <= (state == GAP);
      if (last_beat)     beat <= '0;
      else if (beat_vld) beat <= beat + 1'b1;
    end
  end

  // Pending queue depth. A push landing on a completion cancels the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_cnt <= '0;
      ovf      <= 1'b0;
    end else if (push && !last_beat) begin
      if (pend_cnt == CNT_MAX) ovf <= 1'b1;
      else                     pend_cnt <= pend_cnt + 1'b1;
    end else if (!push && last_beat) begin
      pend_cnt <= pend_cnt - 1'b1;
    end
  end

  // Starvation timer: counts ungranted REQ cycles, saturating; starve latches at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      starve <= 1'b0;
    end else if (beat_vld || state_nxt == IDLE || state_nxt == GAP) begin
      to_cnt <= '0;
    end else if (state == REQ && to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_cnt == TO_MAX - 1'b1) starve <= 1'b1;
    end
  end

endmodule

// File: rtl/arb_req_ctrl.sv
// Purpose: requester-side controller for a registered fixed-priority arbiter, N clients.
// Latency: push at t -> req at t+2; done pulses the cycle after the BURST-th granted beat.
// Backpressure: none on push; saturated pushes are dropped and flagged in ovf.
//
// Ports: push[N] per-client requests, gnt[N] arbiter grants (one-hot or zero),
// req[N] registered requests, busy[N] client in REQ/XFER, done[N] completion
// pulses, pend_cnt[N*CNT_W] flattened pending counts (client i at i*CNT_W),
// ovf/starve[N] sticky per-client flags, err sticky grant-protocol violation.
module arb_req_ctrl
  import arb_pkg::*;
#(
  parameter int N     = ARB_N,
  parameter int CNT_W = ARB_CNT_W,
  parameter int BURST = ARB_BURST,
  parameter int TO_W  = ARB_TO_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       push,
  input  logic [N-1:0]       gnt,
  output logic [N-1:0]       req,
  output logic [N-1:0]       busy,
  output logic [N-1:0]       done,
  output logic [N*CNT_W-1:0] pend_cnt,
  output logic [N-1:0]       ovf,
  output logic [N-1:0]       starve,
  output logic               err
);

  logic [N-1:0] idle_gnt;
  logic         multi_gnt;

  for (genvar i = 0; i < N; i++) begin : g_client
    arb_req_client #(
      .CNT_W (CNT_W),
      .BURST (BURST),
      .TO_W  (TO_W)
    ) u_client (
      .clk      (clk),
      .rst      (rst),
      .push     (push[i]),
      .gnt      (gnt[i]),
      .req      (req[i]),
      .done     (done[i]),
      .pend_cnt (pend_cnt[i*CNT_W +: CNT_W]),
      .ovf      (ovf[i]),
      .starve   (starve[i]),
      .idle_gnt (idle_gnt[i])
    );
  end

  assign busy = req;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_gnt = |(gnt & (gnt - N'(1)));

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (multi_gnt || (|idle_gnt)) err <= 1'b1;
  end

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Purpose: directed bench for arb_req_ctrl paired with a registered fixed-priority arbiter.
// Latency: expected done cycles are queued at push time and matched as done pulses appear.
// Backpressure: a force path can override the arbiter grant for protocol and hog scenarios.
module tb_arb_req_ctrl;
  import arb_pkg::*;

  localparam int N     = 4;
  localparam int CNT_W = 3;
  localparam int BURST = 4;
  localparam int TO_W  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       push;
  logic [N-1:0]       gnt;
  logic [N-1:0]       req;
  logic [N-1:0]       busy;
  logic [N-1:0]       done;
  logic [N*CNT_W-1:0] pend_cnt;
  logic [N-1:0]       ovf;
  logic [N-1:0]       starve;
  logic               err;

  logic [N-1:0] pick;
  logic [N-1:0] arb_gnt;
  logic         frc_en;
  logic [N-1:0] frc_val;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int client;
    int at;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  arb_req_ctrl #(
    .N     (N),
    .CNT_W (CNT_W),
    .BURST (BURST),
    .TO_W  (TO_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .gnt      (gnt),
    .req      (req),
    .busy     (busy),
    .done     (done),
    .pend_cnt (pend_cnt),
    .ovf      (ovf),
    .starve   (starve),
    .err      (err)
  );

  // Fixed-priority arbiter: highest requesting index wins, grant registered.
  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++) if (req[i]) pick = N'(1) << i;
  end

  always_ff @(posedge clk) begin
    if (rst) arb_gnt <= '0;
    else     arb_gnt <= pick;
  end

  assign gnt = frc_en ? frc_val : arb_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc(input int i);
    return 32'(pend_cnt[i*CNT_W +: CNT_W]);
  endfunction

  task automatic expect_done(input int client, input int at);
    exp_t e;
    e.client = client;
    e.at     = at;
    sb.push_back(e);
  endtask

  // Advance one cycle, sample 1ns after the edge, and match any done pulse to the queue.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done !== '0) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_client", 32'(done), 32'(N'(1) << e.client));
        chk("done_cycle", cyc, e.at);
      end
    end
  endtask

  task automatic do_reset();
    sb.delete();
    rst    = 1'b1;
    push   = '0;
    frc_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_cyc(input logic [N-1:0] v);
    push = v;
    tick();
    push = '0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int p;
    push    = '0;
    frc_en  = 1'b0;
    frc_val = '0;
    rst     = 1'b1;

    // Reset state
    do_reset();
    chk("rst_req", 32'(req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pend", 32'(pend_cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_starve", 32'(starve), 0);
    chk("rst_err", 32'(err), 0);

    // Single push on client 1: req at p+2, beats p+3..p+6, done at p+7
    tick();
    p = cyc;
    expect_done(1, p + 7);
    push_cyc(4'b0010);
    chk("t1_pend", pc(1), 1);
    chk("t1_req_early", 32'(req), 0);
    tick();
    chk("t1_req", 32'(req), 32'b0010);
    tick();
    chk("t1_gnt_first", 32'(gnt), 32'b0010);
    repeat (3) tick();
    chk("t1_gnt_last", 32'(gnt), 32'b0010);
    tick();
    chk("t1_req_low", 32'(req), 0);
    chk("t1_pend_zero", pc(1), 0);
    chk("t1_done_seen", sb.size(), 0);
    tick();
    chk("t1_gnt_low", 32'(gnt), 0);

    // Clients 0 and 3 together: 3 wins, 0 granted right after 3's GAP
    tick();
    p = cyc;
    expect_done(3, p + 7);
    expect_done(0, p + 12);
    push_cyc(4'b1001);
    tick();
    chk("t2_req", 32'(req), 32'b1001);
    repeat (5) tick();
    chk("t2_req_after_done3", 32'(req), 32'b0001);
    tick();
    chk("t2_gnt0", 32'(gnt), 32'b0001);
    repeat (4) tick();
    chk("t2_done_seen", sb.size(), 0);

    // Preemption: client 0 gets 2 beats, client 2 takes over, client 0 needs exactly 2 more
    tick();
    p = cyc;
    expect_done(2, p + 9);
    expect_done(0, p + 12);
    push_cyc(4'b0001);
    tick();
    push_cyc(4'b0100);
    chk("t3_beat1", 32'(gnt), 32'b0001);
    tick();
    chk("t3_beat2", 32'(gnt), 32'b0001);
    tick();
    chk("t3_preempt", 32'(gnt), 32'b0100);
    tick();
    chk("t3_req_held", 32'(req), 32'b0101);
    repeat (4) tick();
    chk("t3_resume", 32'(gnt), 32'b0001);
    repeat (2) tick();
    chk("t3_done_seen", sb.size(), 0);

    // Saturation: client 3 holds the bus while client 2 is pushed 8 times
    tick();
    p = cyc;
    expect_done(3, p + 7);
    // Each follow-on burst costs GAP + one arbiter cycle + BURST beats
    for (int k = 0; k < 7; k++) expect_done(2, p + 12 + k * (BURST + 2));
    push = 4'b1100;
    tick();
    push = 4'b0100;
    repeat (6) tick();
    chk("t4_pend_full", pc(2), 7);
    chk("t4_ovf_clear", 32'(ovf), 0);
    tick();
    push = '0;
    chk("t4_pend_sat", pc(2), 7);
    chk("t4_ovf", 32'(ovf), 32'b0100);
    repeat (4) tick();
    chk("t4_pend_dec", pc(2), 6);
    drain(100);
    chk("t4_ovf_sticky", 32'(ovf), 32'b0100);

    // Starvation: grant parked on client 3 (forced) while client 0 waits
    do_reset();
    tick();
    p = cyc;
    expect_done(3, p + 6);
    expect_done(3, p + 11);
    expect_done(3, p + 16);
    expect_done(3, p + 21);
    expect_done(0, p + 26);
    push = 4'b1001;
    tick();
    push = 4'b1000;
    tick();
    frc_val = 4'b1000;
    frc_en  = 1'b1;
    tick();
    tick();
    push = '0;
    repeat (12) tick();
    chk("t5_starve_pre", 32'(starve), 0);
    tick();
    chk("t5_starve", 32'(starve), 32'b0001);
    repeat (5) tick();
    frc_en = 1'b0;
    drain(40);
    chk("t5_starve_keep", 32'(starve), 32'b0001);
    chk("t5_err", 32'(err), 0);

    // Idle grant: the cycle after GAP is exempt, the one after that is not
    do_reset();
    tick();
    p = cyc;
    expect_done(0, p + 7);
    push_cyc(4'b0001);
    repeat (7) tick();
    frc_val = 4'b0001;
    frc_en  = 1'b1;
    tick();
    frc_en = 1'b0;
    chk("t6_exempt", 32'(err), 0);
    tick();
    chk("t6_exempt_hold", 32'(err), 0);
    frc_en = 1'b1;
    tick();
    frc_en = 1'b0;
    chk("t6_idle_gnt", 32'(err), 1);
    repeat (3) tick();
    chk("t6_sticky", 32'(err), 1);

    // Multi-bit grant while both clients request, then reset mid-burst
    do_reset();
    tick();
    p = cyc;
    push_cyc(4'b0101);
    tick();
    chk("t7_err_pre", 32'(err), 0);
    frc_val = 4'b0101;
    frc_en  = 1'b1;
    tick();
    frc_en = 1'b0;
    chk("t7_multi_gnt", 32'(err), 1);
    tick();
    chk("t7_busy_mid", 32'(busy), 32'b0101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_req", 32'(req), 0);
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_done", 32'(done), 0);
    chk("t7_rst_pend", 32'(pend_cnt), 0);
    chk("t7_rst_ovf", 32'(ovf), 0);
    chk("t7_rst_starve", 32'(starve), 0);
    chk("t7_rst_err", 32'(err), 0);
    repeat (3) tick();
    chk("t7_req_stays_low", 32'(req), 0);
    chk("t7_gnt_low", 32'(gnt), 0);

    chk("end_queue_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
